// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: shares one sync_fifo write port between NUM_REQ requesters with credit-checked grants
// Ports: clk_i/rst_n_i clock and async active-low reset; req_i/req_data_i requester words;
//   gnt_o one-hot combinational grant; fifo_cs_o/fifo_wr_en_o/fifo_data_in_o registered FIFO write side;
//   fifo_rd_en_i/fifo_empty_i/fifo_full_i snooped FIFO read side; level_o committed occupancy.
// Build option: SYNC_FIFO_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_cs_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
  input  logic                          fifo_rd_en_i,
  input  logic                          fifo_empty_i,
  input  logic                          fifo_full_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  logic [PW-1:0] win, idx;
  logic hit, can_grant, accept, rd_fire, wr_en_q, cs_q;
  logic [LW-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // rst_n_i gates the grant so it drops the instant reset is asserted
  assign can_grant = (level_q < LW'(FIFO_DEPTH)) && !fifo_full_i && rst_n_i;
`ifdef SYNC_FIFO_ARB_FIXED_PRIO_EN
  // descending scan: the lowest set request is the last assignment and wins
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'(k);
      if (req_i[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  // descending scan of offsets from rr_ptr: the nearest set request wins
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_i[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  assign rr_ptr_d = accept ? ((int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1) : rr_ptr_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
`endif
  assign gnt_o = (hit && can_grant) ? (NUM_REQ'(1) << win) : '0;
  assign accept = |gnt_o;
  // a read only frees credit once it lands; the level guard keeps the count from underflowing
  assign rd_fire = fifo_rd_en_i && !fifo_empty_i && (level_q != '0);
  assign level_d = level_q + LW'(accept) - LW'(rd_fire);
  assign data_d = accept ? req_data_i[win*DATA_WIDTH +: DATA_WIDTH] : data_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      level_q <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      cs_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      wr_en_q <= accept;
      data_q  <= data_d;
      cs_q    <= 1'b1;
    end
  assign fifo_cs_o = cs_q;
  assign fifo_wr_en_o = wr_en_q;
  assign fifo_data_in_o = data_q;
  assign level_o = level_q;
endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb_sync_fifo_wr_arbiter: self-checking bench with a queue-based FIFO and requester model
module tb_sync_fifo_wr_arbiter;
  localparam int N = 4, D = 8, W = 32;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] gnt;
  logic cs, wr_en, rd_en = 0, f_empty = 1, f_full = 0;
  logic [W-1:0] data_in;
  logic [3:0] level;
  int checks = 0, errors = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] rq[N][$];
  int m_level = 0, m_ptr = 0;
  bit m_wr = 0, m_cs = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] s_gnt;
  logic [3:0] s_level;
  typedef struct {logic [N-1:0] req; bit rd; logic [N-1:0] gnt; int level;} vec_t;
  vec_t tbl[13];

  sync_fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_data_i(req_data), .gnt_o(gnt),
    .fifo_cs_o(cs), .fifo_wr_en_o(wr_en), .fifo_data_in_o(data_in),
    .fifo_rd_en_i(rd_en), .fifo_empty_i(f_empty), .fifo_full_i(f_full), .level_o(level));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int p);
`ifdef SYNC_FIFO_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = rq[i].size() != 0;
      req_data[i*W +: W] = req[i] ? rq[i][0] : '0;
    end
  endtask

  // one clock: compare at negedge, update models at posedge, return at posedge+1
  task automatic tick();
    int w;
    bit acc, rde, sw;
    logic [N-1:0] eg;
    logic [W-1:0] sd;
    @(negedge clk);
    w = pick(req, m_ptr);
    acc = rst_n && w >= 0 && m_level < D && fq.size() < D;
    eg = '0;
    if (acc) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    chk("wr_en", wr_en, m_wr);
    chk("data_in", data_in, m_data);
    chk("level", level, m_level);
    chk("cs", cs, m_cs);
    s_gnt = gnt;
    s_level = level;
    sw = wr_en;
    sd = data_in;
    rde = rd_en && fq.size() != 0;
    @(posedge clk);
    if (sw) chk("no_overflow", fq.size() < D, 1);
    if (rde) void'(fq.pop_front());
    if (sw) fq.push_back(sd);
    m_level = m_level + int'(acc) - int'(rde && m_level > 0);
    m_wr = acc;
    if (acc) begin
      m_data = req_data[w*W +: W];
      m_ptr = (w + 1) % N;
      if (rq[w].size() != 0) void'(rq[w].pop_front());
    end
    m_cs = 1;
    #1;
    f_empty = fq.size() == 0;
    f_full = fq.size() == D;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req = '0;
    rd_en = 0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_cs", cs, 0);
    chk("rst_level", level, 0);
    m_level = 0; m_ptr = 0; m_wr = 0; m_cs = 0; m_data = '0;
    fq.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    f_empty = 1;
    f_full = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 13; i++) begin
      tbl[i].req = 4'hF;
      tbl[i].rd = (i == 9);
      tbl[i].level = (i <= 8) ? i : (i == 10) ? 7 : 8;
`ifdef SYNC_FIFO_ARB_FIXED_PRIO_EN
      tbl[i].gnt = (i < 8 || i == 10) ? 4'b0001 : 4'b0000;
`else
      tbl[i].gnt = (i < 8) ? 4'(1 << (i % 4)) : (i == 10) ? 4'b0001 : 4'b0000;
`endif
    end
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h10 + i;
    do_reset();
    // ordered write from requester 0
    req = 4'b0001;
    req_data[0 +: W] = 32'hA1; tick();
    req_data[0 +: W] = 32'hB2; tick();
    req_data[0 +: W] = 32'hC3; tick();
    req = '0;
    tick(); tick();
    chk("ord_level", level, 3);
    chk("ord_cnt", fq.size(), 3);
    if (fq.size() == 3) begin
      chk("ord_w0", fq[0], 32'hA1);
      chk("ord_w1", fq[1], 32'hB2);
      chk("ord_w2", fq[2], 32'hC3);
    end
    // read on an empty FIFO while the write is still pending
    do_reset();
    req = 4'b0001;
    req_data[0 +: W] = 32'h55;
    tick();
    req = '0;
    rd_en = 1;
    tick();
    rd_en = 0;
    tick();
    chk("empty_rd_level", level, 1);
    chk("empty_rd_cnt", fq.size(), 1);
    if (fq.size() == 1) chk("empty_rd_word", fq[0], 32'h55);
    // fairness, full boundary and full release
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h10 + i;
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      rd_en = tbl[i].rd;
      tick();
      chk($sformatf("tbl_gnt%0d", i), s_gnt, tbl[i].gnt);
      chk($sformatf("tbl_level%0d", i), s_level, tbl[i].level);
    end
    rd_en = 0;
    chk("full_cnt", fq.size(), D);
    // asynchronous reset with a write pending
    do_reset();
    req = 4'hF;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("mid_gnt", gnt, 0);
    chk("mid_wr_en", wr_en, 0);
    chk("mid_level", level, 0);
    m_level = 0; m_ptr = 0; m_wr = 0; m_cs = 0; m_data = '0;
    fq.delete();
    f_empty = 1;
    f_full = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("post_rst_gnt", s_gnt, 4'b0001);
    tick();
    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rdp;
      rdp = ((c / 300) % 2) ? 15 : 70;
      if ($urandom_range(0, 99) < 60) rq[$urandom_range(0, N - 1)].push_back($urandom);
      rd_en = $urandom_range(0, 99) < rdp;
      drive_req();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
